// File: rtl/div4_window_tally_if.sv
// div4_window_tally_if: sample stream handshake and window statistics bundle.
interface div4_window_tally_if #(
   parameter int N      = 4,
   parameter int WINDOW = 100,
   parameter int CW     = $clog2(WINDOW + 1)
);
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  x;
   logic          d_valid;
   logic          d;
   logic [N-1:0]  d_x;
   logic [CW-1:0] hits;
   logic [CW-1:0] count;
   logic          busy;
   logic          done;
   modport master (
      output start, in_valid, x,
      input  in_ready, d_valid, d, d_x, hits, count, busy, done
   );
   modport slave (
      input  start, in_valid, x,
      output in_ready, d_valid, d, d_x, hits, count, busy, done
   );
endinterface

// File: rtl/div4_window_tally.sv
// div4_window_tally: registers the divisible-by-4 flag per accepted sample and
// tallies hits over a window of WINDOW accepts, pulsing done at completion.
module div4_window_tally #(
   parameter int N      = 4,
   parameter int WINDOW = 100,
   parameter int CW     = $clog2(WINDOW + 1)
) (
   input logic              clk,
   input logic              rst_n,
   div4_window_tally_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
   state_t        state_q, state_d;
   logic          d_valid_q, d_q;
   logic [N-1:0]  d_x_q;
   logic [CW-1:0] hits_q, hits_d, count_q, count_d;
   logic          accept, d_new;
   assign accept = (state_q == RUN) && bus.in_valid;
   assign d_new  = ~|bus.x[1:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.start ? RUN : IDLE;
         RUN:     state_d = (accept && count_q == LAST) ? DONE : RUN;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.in_ready = state_q == RUN;
      bus.busy     = state_q != IDLE;
      bus.done     = state_q == DONE;
   end
   // the start edge out of IDLE clears the tallies; otherwise only accepts move them
   always_comb begin
      count_d = (state_q == IDLE && bus.start) ? '0 : accept ? count_q + 1'b1 : count_q;
      hits_d  = (state_q == IDLE && bus.start) ? '0 : accept ? hits_q + CW'(d_new) : hits_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         d_valid_q <= 1'b0;
         d_q       <= 1'b0;
         d_x_q     <= '0;
         hits_q    <= '0;
         count_q   <= '0;
      end else begin
         d_valid_q <= accept;
         hits_q    <= hits_d;
         count_q   <= count_d;
         if (accept) begin
            d_q   <= d_new;
            d_x_q <= bus.x;
         end
      end
   assign bus.d_valid = d_valid_q;
   assign bus.d       = d_q;
   assign bus.d_x     = d_x_q;
   assign bus.hits    = hits_q;
   assign bus.count   = count_q;
endmodule

// File: tb/tb_div4_window_tally.sv
// tb_div4_window_tally: randomized and directed checks of the windowed div-by-4 tally
// across four window sizes against a queue-based reference model.
module tb_div4_window_tally;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   div4_window_tally_if #(.N(8), .WINDOW(100)) ia ();
   div4_window_tally_if #(.N(4), .WINDOW(4))   ib ();
   div4_window_tally_if #(.N(8), .WINDOW(3))   ic ();
   div4_window_tally_if #(.N(8), .WINDOW(1))   id ();
   div4_window_tally #(.N(8), .WINDOW(100)) ua (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   div4_window_tally #(.N(4), .WINDOW(4))   ub (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
   div4_window_tally #(.N(8), .WINDOW(3))   uc (.clk(clk), .rst_n(rst_n), .bus(ic.slave));
   div4_window_tally #(.N(8), .WINDOW(1))   ud (.clk(clk), .rst_n(rst_n), .bus(id.slave));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      for (int i = 0; i < 37; i++) begin
         ia.in_valid = 1'b1;
         ia.x = 8'($urandom);
         tick();
      end
      n_cmp++; if (ia.count !== 7'd37) begin n_bad++; $display("FAIL pre_reset_count got %0d want 37", ia.count); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (ia.count !== 7'd0 || ia.busy !== 1'b0) begin n_bad++; $display("FAIL async_reset got count=%0d busy=%b want 0 0", ia.count, ia.busy); end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if ({ia.in_ready, ia.d_valid, ia.d, ia.d_x, ia.hits, ia.count, ia.busy, ia.done} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs cyc=%0d got rdy=%b dv=%b d=%b dx=%0d hits=%0d cnt=%0d busy=%b done=%b want all 0",
                     i, ia.in_ready, ia.d_valid, ia.d, ia.d_x, ia.hits, ia.count, ia.busy, ia.done);
         end
      end
      ia.in_valid = 1'b0;
   endtask
   task automatic test_directed;
      logic [3:0] xs [4] = '{4'd0, 4'd4, 4'd5, 4'd14};
      int hits_m = 0;
      ib.start = 1'b1;
      tick();
      ib.start = 1'b0;
      n_cmp++; if (ib.in_ready !== 1'b1 || ib.busy !== 1'b1) begin n_bad++; $display("FAIL dir_run got rdy=%b busy=%b want 1 1", ib.in_ready, ib.busy); end
      for (int i = 0; i < 4; i++) begin
         ib.x = xs[i];
         ib.in_valid = 1'b1;
         hits_m += (xs[i] % 4 == 0) ? 1 : 0;
         tick();
         n_cmp++;
         if (ib.d_valid !== 1'b1 || ib.d !== (xs[i] % 4 == 0) || ib.d_x !== xs[i] || ib.count !== 3'(i + 1)) begin
            n_bad++;
            $display("FAIL dir_sample%0d got dv=%b d=%b dx=%0d cnt=%0d want 1 %b %0d %0d",
                     i, ib.d_valid, ib.d, ib.d_x, ib.count, xs[i] % 4 == 0, xs[i], i + 1);
         end
      end
      n_cmp++; if (ib.done !== 1'b1 || ib.in_ready !== 1'b0 || ib.hits !== 3'(hits_m)) begin n_bad++; $display("FAIL dir_done got done=%b rdy=%b hits=%0d want 1 0 %0d", ib.done, ib.in_ready, ib.hits, hits_m); end
      ib.in_valid = 1'b0;
      tick();
      n_cmp++; if (ib.done !== 1'b0 || ib.busy !== 1'b0 || ib.d_valid !== 1'b0) begin n_bad++; $display("FAIL dir_idle got done=%b busy=%b dv=%b want 0 0 0", ib.done, ib.busy, ib.d_valid); end
   endtask
   task automatic test_gapped;
      logic       vs [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] xs [6] = '{8'd8, 8'd3, 8'd3, 8'd12, 8'd1, 8'd2};
      int ndone = 0;
      ic.start = 1'b1;
      tick();
      ic.start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         ic.in_valid = (i < 6) ? vs[i] : 1'b1;
         ic.x = (i < 6) ? xs[i] : 8'd0;
         tick();
         ndone += ic.done ? 1 : 0;
         if (i == 5) begin
            n_cmp++; if (ic.d_x !== 8'd2 || ic.d !== 1'b0 || ic.done !== 1'b1) begin n_bad++; $display("FAIL gap_last got dx=%0d d=%b done=%b want 2 0 1", ic.d_x, ic.d, ic.done); end
         end
      end
      ic.in_valid = 1'b0;
      n_cmp++; if (ic.hits !== 2'd2 || ic.count !== 2'd3 || ndone != 1) begin n_bad++; $display("FAIL gap_totals got hits=%0d cnt=%0d dones=%0d want 2 3 1", ic.hits, ic.count, ndone); end
   endtask
   task automatic test_start_ignored;
      ic.start = 1'b1;
      tick();
      ic.x = 8'd0;
      ic.in_valid = 1'b1;
      tick();
      n_cmp++; if (ic.count !== 2'd1 || ic.hits !== 2'd1) begin n_bad++; $display("FAIL ign_run got cnt=%0d hits=%0d want 1 1", ic.count, ic.hits); end
      ic.start = 1'b0;
      ic.x = 8'd4;
      tick();
      ic.x = 8'd1;
      tick();
      ic.in_valid = 1'b0;
      ic.start = 1'b1;
      tick();
      ic.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (ic.busy !== 1'b0 || ic.count !== 2'd3 || ic.hits !== 2'd2) begin n_bad++; $display("FAIL ign_hold cyc=%0d got busy=%b cnt=%0d hits=%0d want 0 3 2", i, ic.busy, ic.count, ic.hits); end
      end
      ic.start = 1'b1;
      tick();
      ic.start = 1'b0;
      n_cmp++; if (ic.busy !== 1'b1 || ic.count !== 2'd0 || ic.hits !== 2'd0) begin n_bad++; $display("FAIL ign_restart got busy=%b cnt=%0d hits=%0d want 1 0 0", ic.busy, ic.count, ic.hits); end
   endtask
   task automatic test_random;
      logic [7:0] acc_q[$];
      int  hits_m;
      bit  fin = 0;
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
         logic       v;
         logic [7:0] xv;
         v = ($urandom % 4) != 0;
         xv = 8'($urandom);
         ia.in_valid = v;
         ia.x = v ? xv : 8'bx;
         if (v) acc_q.push_back(xv);
         tick();
         n_cmp++; if (ia.d_valid !== v) begin n_bad++; $display("FAIL rnd_dvalid cyc=%0d got %b want %b", cyc, ia.d_valid, v); end
         if (v) begin
            n_cmp++; if (ia.d_x !== xv || ia.d !== (xv % 4 == 0)) begin n_bad++; $display("FAIL rnd_sample cyc=%0d got dx=%0d d=%b want %0d %b", cyc, ia.d_x, ia.d, xv, xv % 4 == 0); end
         end
         if (ia.d_valid === 1'b1) begin
            n_cmp++; if (ia.d !== (ia.d_x[1:0] == 2'b00)) begin n_bad++; $display("FAIL rnd_flag cyc=%0d got d=%b for dx=%0d", cyc, ia.d, ia.d_x); end
         end
         n_cmp++; if (ia.done !== (acc_q.size() == 100)) begin n_bad++; $display("FAIL rnd_done cyc=%0d got %b want %b", cyc, ia.done, acc_q.size() == 100); end
         fin = acc_q.size() == 100;
      end
      ia.in_valid = 1'b0;
      hits_m = 0;
      foreach (acc_q[i]) hits_m += (acc_q[i] % 4 == 0) ? 1 : 0;
      n_cmp++; if (!fin || ia.count !== 7'd100 || ia.hits !== 7'(hits_m)) begin n_bad++; $display("FAIL rnd_totals fin=%0d got cnt=%0d hits=%0d want 100 %0d", fin, ia.count, ia.hits, hits_m); end
      tick();
   endtask
   task automatic test_boundary;
      id.start = 1'b1;
      tick();
      id.start = 1'b0;
      n_cmp++; if (id.in_ready !== 1'b1) begin n_bad++; $display("FAIL bnd_ready got %b want 1", id.in_ready); end
      id.x = 8'd255;
      id.in_valid = 1'b1;
      tick();
      id.in_valid = 1'b0;
      n_cmp++; if (id.d_valid !== 1'b1 || id.d !== 1'b0 || id.done !== 1'b1 || id.hits !== 1'd0 || id.count !== 1'd1 || id.in_ready !== 1'b0) begin
         n_bad++; $display("FAIL bnd_accept got dv=%b d=%b done=%b hits=%0d cnt=%0d rdy=%b want 1 0 1 0 1 0", id.d_valid, id.d, id.done, id.hits, id.count, id.in_ready);
      end
      tick();
      n_cmp++; if (id.done !== 1'b0 || id.busy !== 1'b0) begin n_bad++; $display("FAIL bnd_idle got done=%b busy=%b want 0 0", id.done, id.busy); end
      id.start = 1'b1;
      tick();
      id.start = 1'b0;
      n_cmp++; if (id.count !== 1'd0 || id.busy !== 1'b1 || id.in_ready !== 1'b1) begin n_bad++; $display("FAIL bnd_restart got cnt=%0d busy=%b rdy=%b want 0 1 1", id.count, id.busy, id.in_ready); end
      id.x = 8'd4;
      id.in_valid = 1'b1;
      tick();
      id.in_valid = 1'b0;
      n_cmp++; if (id.done !== 1'b1 || id.hits !== 1'd1 || id.count !== 1'd1 || id.d !== 1'b1) begin n_bad++; $display("FAIL bnd_second got done=%b hits=%0d cnt=%0d d=%b want 1 1 1 1", id.done, id.hits, id.count, id.d); end
      tick();
   endtask
   initial begin
      {ia.start, ia.in_valid, ia.x} = '0;
      {ib.start, ib.in_valid, ib.x} = '0;
      {ic.start, ic.in_valid, ic.x} = '0;
      {id.start, id.in_valid, id.x} = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
      test_reset();
      test_directed();
      test_gapped();
      test_start_ignored();
      test_random();
      test_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
